// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the 10b-symbol to 4b-lane transmit gearbox.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // K28.5 with negative running disparity: the comma used as the idle filler.
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;

  // PRBS7, x^7 + x^6 + 1: feedback is state[6] ^ state[5].
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;

endpackage

// File: rtl/serial_tx_gearbox_prbs7.sv
// PRBS7 generator producing 4 sequential bits per clock, oldest bit in bits[3].
// Latency: bits is combinational from the LFSR state; the state advances on each enabled edge.
// Backpressure: en low freezes the sequence so it resumes without skipping bits.
//
// Ports: clk_312p5mhz, rst_n (async, active-low), en (advance 4 steps), bits (next 4 bits).
module prbs7_gen
  import serial_tx_pkg::*;
(
  input  logic       clk_312p5mhz,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] bits
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Unroll four serial Fibonacci steps; each feedback bit is also the emitted bit.
  always_comb begin
    logic fb;
    lfsr_d = lfsr_q;
    bits   = '0;
    for (int i = 0; i < 4; i++) begin
      fb     = ^(lfsr_d & PRBS7_TAPS);
      bits   = {bits[2:0], fb};
      lfsr_d = {lfsr_d[5:0], fb};
    end
  end

  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/serial_tx_gearbox.sv
// Gearbox from 10-bit line symbols to a 4-bit-per-clock lane, with K28.5 fill and PRBS7 mode.
// Latency: first symbol bits appear on tx_data one edge after acceptance; all outputs registered.
// Backpressure: sym_ready is register-only; underflow inserts FILL_SYMBOL instead of stalling.
//
// Ports: clk_312p5mhz, rst_n (async, active-low); sym_valid/sym_data/sym_ready symbol input
// (bit 9 first); prbs_en selects PRBS7 output and freezes the buffer; tx_data (bit 3 first);
// underflow pulse and saturating underflow_count.
module serial_tx_gearbox
  import serial_tx_pkg::*;
#(
  parameter bit         INVERT      = 1'b0,
  parameter logic [9:0] FILL_SYMBOL = K28_5_RDN
) (
  input  logic        clk_312p5mhz,
  input  logic        rst_n,
  input  logic        sym_valid,
  input  logic [9:0]  sym_data,
  output logic        sym_ready,
  input  logic        prbs_en,
  output logic [3:0]  tx_data,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  tx_state_t   state_q, state_d;
  logic [13:0] sr_q, sr_d;       // left-aligned bit buffer, oldest bit at [13]
  logic [3:0]  fill_q, fill_d;   // number of valid bits in sr_q
  logic        prbs_q;           // registered prbs_en, keeps sym_ready register-only
  logic [3:0]  tx_d;
  logic        uf_d;
  logic        xfer;
  logic [3:0]  prbs_bits;
  logic [3:0]  fill_cons;
  logic [9:0]  load_sym;
  logic [13:0] load_aligned;

  // prbs_en is a bring-up control; sym_ready follows it one edge late, so a
  // source should not offer symbols in the cycle prbs_en rises while ready is high.
  assign sym_ready = !prbs_q && ((state_q == IDLE) || (fill_q < 4'd8));
  assign xfer      = sym_valid && sym_ready;

  prbs7_gen u_prbs7_gen (
    .clk_312p5mhz (clk_312p5mhz),
    .rst_n        (rst_n),
    .en           (prbs_en),
    .bits         (prbs_bits)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    tx_d      = '0;
    uf_d      = 1'b0;
    fill_cons = fill_q - 4'd4;
    // Without a handshake a load must still happen to keep the lane fed.
    load_sym  = xfer ? sym_data : FILL_SYMBOL;
    // After consuming 4 bits only fill_cons (0..3) bits remain at the top, so
    // the new symbol slots in directly below them.
    load_aligned = {load_sym, 4'b0000} >> fill_cons;

    if (prbs_en) begin
      // Buffer, fill and state hold so the data stream resumes bit-exact.
      tx_d = prbs_bits;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            sr_d    = {sym_data, 4'b0000};
            fill_d  = 4'd10;
            state_d = RUN;
          end
        end
        RUN: begin
          tx_d = sr_q[13:10];
          if (fill_q < 4'd8) begin
            sr_d   = {sr_q[9:0], 4'b0000} | load_aligned;
            fill_d = fill_cons + 4'd10;
            uf_d   = !xfer;
          end else begin
            sr_d   = {sr_q[9:0], 4'b0000};
            fill_d = fill_cons;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sr_q            <= '0;
      fill_q          <= '0;
      prbs_q          <= 1'b0;
      tx_data         <= {4{INVERT}};
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      prbs_q    <= prbs_en;
      tx_data   <= tx_d ^ {4{INVERT}};
      underflow <= uf_d;
      if (uf_d && (underflow_count != 16'hFFFF)) begin
        underflow_count <= underflow_count + 16'd1;
      end
    end
  end

endmodule
